// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the core's load/store port.
// One request at a time on a valid/ready handshake, RISC-V byte/half/word
// sizing from funct3, response after a fixed number of cycles and held
// until the initiator takes it.
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  accept, commit, wr_en, err_c;
  logic [3:0]            be_c;
  logic [DATA_W-1:0]     lanes_c, word_c;
  logic [DM_ADDRESS-3:0] widx;

  logic                  we_p0;
  logic [DM_ADDRESS-1:0] addr_p0;
  logic [DATA_W-1:0]     wdata_p0;
  logic [2:0]            f3_p0;

  logic [DATA_W-1:0]     mem [0:WORDS-1];

  // Illegal funct3 for the access direction, or a misaligned half/word.
  function automatic logic access_err(input logic we, input logic [1:0] a,
                                      input logic [2:0] f3);
    logic bad_code, misaligned;
    if (we) bad_code = f3[2] || (f3[1:0] == 2'b11);
    else    bad_code = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_code || misaligned;
  endfunction

  // Byte-lane enables of a store (little-endian lanes within the word).
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  return 4'b0001 << a;
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Store data replicated onto every lane it may land in.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Select the addressed byte/half and extend it per funct3.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                  input logic [1:0] a,
                                                  input logic [2:0] f3);
    logic [DATA_W-1:0] sh;
    sh = word >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign req_ready = (state == IDLE) && reset;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  // The access itself happens on the edge that enters RESP.
  assign commit    = (state == WAIT) && (cnt == 4'd0);
  assign widx      = addr_p0[DM_ADDRESS-1:2];
  assign err_c     = access_err(we_p0, addr_p0[1:0], f3_p0);
  assign be_c      = store_be(f3_p0, addr_p0[1:0]);
  assign lanes_c   = store_lanes(f3_p0, wdata_p0);
  assign word_c    = mem[widx];
  // Reset on the commit edge cancels the write.
  assign wr_en     = commit && reset && we_p0 && !err_c;

  // Next-state logic: WAIT spans LATENCY cycles, so rsp_valid rises LATENCY edges after accept.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(LATENCY - 1);
      end
      WAIT: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture: inputs are sampled only on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      f3_p0    <= req_funct3;
    end
  end

  // Storage array (never cleared by reset).
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (be_c[b]) mem[widx][8*b +: 8] <= lanes_c[8*b +: 8];
  end

  // Response registers: loaded on RESP entry, held until the handshake clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= err_c;
      rsp_rdata <= (we_p0 || err_c) ? '0 : load_ext(word_c, addr_p0[1:0], f3_p0);
    end else if (rsp_valid && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one task per scenario, inline checks.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v1 = 1'b0, we1 = 1'b0, rr1 = 1'b0;
  logic [8:0]  a1 = '0;
  logic [31:0] wd1 = '0;
  logic [2:0]  f1 = '0;
  logic        ready1, valid1, err1;
  logic [31:0] rd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(ready1),
    .req_we(we1), .req_addr(a1), .req_wdata(wd1), .req_funct3(f1),
    .rsp_valid(valid1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(err1));

  // One full transaction on the LATENCY=2 instance; lat = edges from accept to rsp_valid (99 = timeout).
  task automatic do_req(input logic we, input logic [8:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic er,
                        output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd; req_funct3 = 3'b111;
    lat = 99; rd = '0; er = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (rsp_valid === 1'b1) begin lat = k; break; end
      @(posedge clk); #1;
    end
    if (lat != 99) begin
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_no_accept rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL sw_latency got %0d want 2", lat); end
    tests++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", er, rd); end
    do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL lw_latency got %0d want 2", lat); end
    tests++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got err=%b rdata=%h want 0/deadbeef", er, rd); end
  endtask

  task automatic test_sizing;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 9'h011, 32'h12345680, 3'b000, rd, er, lat);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL sb_err got %b want 0", er); end
    do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
    tests++; if (rd !== 32'hDEAD80EF) begin fails++; $display("FAIL sb_word got %h want dead80ef", rd); end
    do_req(1'b0, 9'h011, 32'h0, 3'b000, rd, er, lat);
    tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h want ffffff80", rd); end
    do_req(1'b0, 9'h011, 32'h0, 3'b100, rd, er, lat);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", rd); end
    do_req(1'b0, 9'h012, 32'h0, 3'b001, rd, er, lat);
    tests++; if (rd !== 32'hFFFFDEAD) begin fails++; $display("FAIL lh got %h want ffffdead", rd); end
    do_req(1'b0, 9'h012, 32'h0, 3'b101, rd, er, lat);
    tests++; if (rd !== 32'h0000DEAD) begin fails++; $display("FAIL lhu got %h want 0000dead", rd); end
    do_req(1'b0, 9'h010, 32'h0, 3'b000, rd, er, lat);
    tests++; if (rd !== 32'hFFFFFFEF) begin fails++; $display("FAIL lb_lane0 got %h want ffffffef", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 9'h012, 32'h55555555, 3'b010, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL sw_misaligned got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 9'h013, 32'h0, 3'b001, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lh_misaligned got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 9'h010, 32'h00000011, 3'b100, rd, er, lat);
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL store_f3_100 got err=%b want 1", er); end
    do_req(1'b0, 9'h010, 32'h0, 3'b011, rd, er, lat);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL load_f3_011 got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat);
    tests++; if (er !== 1'b0 || rd !== 32'hDEAD80EF) begin fails++; $display("FAIL mem_unchanged got err=%b rdata=%h want 0/dead80ef", er, rd); end
  endtask

  task automatic test_backpressure;
    bit seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL bp_timeout rsp_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD80EF || req_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h ready=%b want 1/dead80ef/0",
                          i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL bp_release got valid=%b ready=%b rdata=%h want 0/1/0", rsp_valid, req_ready, rsp_rdata);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat;
    do_req(1'b1, 9'h020, 32'hA5A5A5A5, 3'b010, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_valid got %b want 0", rsp_valid); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_dropped got %b want 0", rsp_valid); end
    do_req(1'b0, 9'h020, 32'h0, 3'b010, rd, er, lat);
    tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL rst_wait_mem got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_latency1;
    bit seen = 0;
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b1; a1 = 9'h004; wd1 = 32'h11223344; f1 = 3'b010;
    @(posedge clk); #1;
    v1 = 1'b0;
    tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL lat1_early got %b want 0", valid1); end
    @(posedge clk); #1;
    tests++; if (valid1 !== 1'b1) begin fails++; $display("FAIL lat1_valid got %b want 1", valid1); end
    rr1 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0;
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b0; a1 = 9'h006; f1 = 3'b101;
    @(posedge clk); #1;
    v1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (valid1 === 1'b1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    tests++; if (!seen || rd1 !== 32'h00001122) begin fails++; $display("FAIL lat1_lhu got seen=%0d rdata=%h want 1/00001122", seen, rd1); end
    rr1 = 1'b1;
    @(posedge clk); #1;
    rr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_sizing();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
